// File: rtl/riscv_lsu.sv
// riscv_lsu -- load/store unit for the MEM stage of the 5-stage RV32I pipeline.
//
// Takes one operation per ex_valid/ex_ready handshake from the EX/MEM register.
// It produces a registered MEM/WB result one cycle after the operation completes.
//   - ALU pass-through: the result is available on the next cycle, with a throughput of one per cycle.
//   - Misaligned or illegal access: no memory request is issued. A one-cycle lsu_err pulse
//     is raised with the faulting address, and a wb_valid with wb_en=0.
//   - Load/store: the unit issues a request on the dmem port and holds it until dmem_gnt.
//     A load then waits for dmem_rvalid, and the loaded value is extracted and extended.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   ex_valid / ex_ready : upstream handshake (ex_ready low stalls EX)
//   ex_mem_read/write   : load / store select (both low = pass-through)
//   ex_funct3           : RV32I width and sign code
//   ex_addr             : ALU result / effective address
//   ex_store_data       : forwarded rs2
//   ex_rd, ex_wb_en     : destination register and writeback enable
//   dmem_*              : data-memory request/grant/response port
//   wb_valid/en/rd/data : registered MEM/WB result
//   lsu_err, lsu_err_addr : misaligned/illegal access pulse and captured address
module riscv_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wb_en,
  output logic            dmem_req,
  input  logic            dmem_gnt,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            lsu_err,
  output logic [XLEN-1:0] lsu_err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t state, state_next;

  logic            accept;
  logic            is_load, is_store, funct3_ok, misaligned, op_err;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [XLEN-1:0] load_shifted, load_result;

  // Operation context held while the memory access is in flight
  logic [2:0]      op_funct3;
  logic [1:0]      op_offset;
  logic [4:0]      op_rd;
  logic            op_wb_en;
  logic            op_is_load;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: only a legal load/store leaves IDLE; error and
  // pass-through operations complete directly from IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (is_load || is_store) && !op_err) state_next = REQ;
      REQ:     if (dmem_gnt) state_next = op_is_load ? WAIT_R : IDLE;
      WAIT_R:  if (dmem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: upstream is only accepted while idle
  always_comb begin
    ex_ready = (state == IDLE);
    accept   = ex_valid && ex_ready;
  end

  // Decode of the incoming operation. Read and write both high is classed as an error,
  // not as a load or a store.
  always_comb begin
    is_load    = ex_mem_read && !ex_mem_write;
    is_store   = ex_mem_write && !ex_mem_read;
    funct3_ok  = 1'b0;
    if (is_load)
      funct3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                  (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    else if (is_store)
      funct3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   misaligned = ex_addr[0];
      2'b10:   misaligned = |ex_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    op_err = (ex_mem_read && ex_mem_write) ||
             ((is_load || is_store) && (!funct3_ok || misaligned));
  end

  // Store lane enables and data replication. The data is copied into every
  // lane so that the byte enables alone select what memory writes.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << ex_addr[1:0];
        store_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << ex_addr[1:0];
        store_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: shift the addressed byte/halfword down to bit 0, then extend it
  always_comb begin
    load_shifted = dmem_rdata >> {op_offset, 3'b000};
    case (op_funct3)
      3'b000:  load_result = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_result = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_result = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
      3'b101:  load_result = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
      default: load_result = load_shifted;
    endcase
  end

  // Registered datapath. dmem outputs are held unchanged through REQ until a grant arrives.
  // wb_valid and lsu_err default low, which makes them one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      lsu_err      <= 1'b0;
      lsu_err_addr <= '0;
      op_funct3    <= 3'b000;
      op_offset    <= 2'b00;
      op_rd        <= 5'd0;
      op_wb_en     <= 1'b0;
      op_is_load   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_err) begin
              wb_valid     <= 1'b1;
              wb_en        <= 1'b0;
              wb_rd        <= ex_rd;
              wb_data      <= '0;
              lsu_err      <= 1'b1;
              lsu_err_addr <= ex_addr;
            end else if (is_load || is_store) begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
              dmem_be    <= is_store ? store_be : 4'b1111;
              dmem_wdata <= is_store ? store_wdata : '0;
              op_funct3  <= ex_funct3;
              op_offset  <= ex_addr[1:0];
              op_rd      <= ex_rd;
              op_wb_en   <= ex_wb_en;
              op_is_load <= is_load;
            end else begin
              wb_valid <= 1'b1;
              wb_en    <= ex_wb_en;
              wb_rd    <= ex_rd;
              wb_data  <= ex_addr;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (!op_is_load) begin
              wb_valid <= 1'b1;
              wb_en    <= 1'b0;
              wb_rd    <= op_rd;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_en    <= op_wb_en;
            wb_rd    <= op_rd;
            wb_data  <= load_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu -- scoreboard bench for riscv_lsu. Each operation pushes its
// expected writeback (and memory request, if any) onto queues. A behavioural
// memory responds with configurable grant/response delays, and a monitor pops
// and compares each wb_valid pulse.
module tb_riscv_lsu;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_wb_en;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_en, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, lsu_err_addr;

  exp_t exp_q[$];
  req_t req_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_delay = 0;
  int rvalid_delay = 1;
  logic [31:0] mem_word = 32'h80FF_7F01;
  int last_stalls = 0;
  int last_accept_cyc = 0;
  int last_wb_cyc = 0;

  riscv_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_err(lsu_err), .lsu_err_addr(lsu_err_addr)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the expected results, present the operation, and wait (bounded) for
  // the edge that accepts it. Returns #1 after that edge, with ex_valid still high.
  task automatic applyStimulus(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic wen,
                               input logic exp_err, input logic exp_en, input logic [31:0] exp_data,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic push_exp, input logic check_next);
    exp_t e;
    req_t r;
    logic rdy;
    if (push_exp) begin
      e.en = exp_en; e.rd = rd; e.data = exp_data; e.err = exp_err; e.err_addr = addr;
      exp_q.push_back(e);
    end
    if ((rd_op ^ wr_op) && !exp_err) begin
      r.we = wr_op; r.addr = addr & 32'hFFFF_FFFC; r.be = exp_be; r.wdata = exp_wdata;
      req_q.push_back(r);
    end
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_funct3 = f3; ex_addr = addr;
    ex_store_data = sdata; ex_rd = rd; ex_wb_en = wen; ex_valid = 1'b1;
    last_stalls = 0;
    rdy = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rdy = ex_ready;
      @(posedge clk); #1;
      if (rdy) break;
      last_stalls++;
    end
    if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
    last_accept_cyc = cyc;
    if (check_next) checkOutput("next_cycle_wb_valid", 32'(wb_valid), 32'd1);
    if (exp_err) checkOutput("err_no_dmem_req", 32'(dmem_req), 32'd0);
  endtask

  task automatic waitDrain(input string tag);
    ex_valid = 1'b0;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Behavioural data memory: grants after gnt_delay cycles of request, answers
  // loads rvalid_delay cycles after the grant. A pending response is not cancelled
  // by reset, which is how a late rvalid reaches the DUT.
  initial begin
    int   waited;
    int   rv_cnt;
    bit   rv_pending;
    req_t r;
    waited = 0; rv_cnt = 0; rv_pending = 0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_cnt <= 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_word;
          rv_pending  = 0;
        end else rv_cnt--;
      end
      if (rst) waited = 0;
      else if (dmem_req) begin
        if (req_q.size() == 0) checkOutput("unexpected_dmem_req", 32'd1, 32'd0);
        else begin
          r = req_q[0];
          checkOutput("req_we", 32'(dmem_we), 32'(r.we));
          checkOutput("req_addr", dmem_addr, r.addr);
          checkOutput("req_be", 32'(dmem_be), 32'(r.be));
          if (r.we) checkOutput("req_wdata", dmem_wdata, r.wdata);
          checkOutput("req_stall_ex_ready", 32'(ex_ready), 32'd0);
          if (waited >= gnt_delay) begin
            dmem_gnt = 1'b1;
            waited = 0;
            void'(req_q.pop_front());
            if (!r.we) begin
              rv_pending = 1;
              rv_cnt = rvalid_delay - 1;
            end
          end else waited++;
        end
      end
    end
  end

  // Writeback monitor: every wb_valid pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_valid) begin
          last_wb_cyc = cyc;
          if (exp_q.size() == 0) checkOutput("unexpected_wb_valid", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            checkOutput("wb_en", 32'(wb_en), 32'(e.en));
            if (e.en) begin
              checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
              checkOutput("wb_data", wb_data, e.data);
            end
            checkOutput("lsu_err", 32'(lsu_err), 32'(e.err));
            if (e.err) checkOutput("lsu_err_addr", lsu_err_addr, e.err_addr);
          end
        end else checkOutput("lsu_err_idle", 32'(lsu_err), 32'd0);
      end
    end
  end

  // Main sequence
  initial begin
    logic [2:0]  lf3  [0:6];
    logic [31:0] laddr[0:6];
    logic [31:0] lexp [0:6];
    int          dly  [0:1];

    rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'b000; ex_addr = '0; ex_store_data = '0; ex_rd = 5'd0; ex_wb_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_dmem_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_dmem_be", 32'(dmem_be), 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_lsu_err", 32'(lsu_err), 32'd0);
    checkOutput("rst_lsu_err_addr", lsu_err_addr, 32'd0);
    rst = 1'b0;

    // ALU pass-through
    applyStimulus(0, 0, 3'b000, 32'h0000_0007, 32'h0, 5'd5, 1, 0, 1, 32'h0000_0007, 4'h0, 32'h0, 1, 1);
    waitDrain("passthru_drain");

    // Stores, SB first with grant held off for two cycles
    gnt_delay = 2;
    applyStimulus(0, 1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd0, 0, 0, 0, 32'h0, 4'b1000, 32'hABAB_ABAB, 1, 0);
    waitDrain("sb_drain");
    gnt_delay = 0;
    applyStimulus(0, 1, 3'b001, 32'h0000_0102, 32'h1234_56AB, 5'd0, 0, 0, 0, 32'h0, 4'b1100, 32'h56AB_56AB, 1, 0);
    waitDrain("sh_drain");
    applyStimulus(0, 1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1, 0);
    waitDrain("sw_drain");

    // Loads from the word 0x80FF_7F01 at 0x200, each with short and long response delay
    lf3[0] = 3'b000; laddr[0] = 32'h201; lexp[0] = 32'h0000_007F;
    lf3[1] = 3'b000; laddr[1] = 32'h203; lexp[1] = 32'hFFFF_FF80;
    lf3[2] = 3'b100; laddr[2] = 32'h202; lexp[2] = 32'h0000_00FF;
    lf3[3] = 3'b001; laddr[3] = 32'h202; lexp[3] = 32'hFFFF_80FF;
    lf3[4] = 3'b010; laddr[4] = 32'h200; lexp[4] = 32'h80FF_7F01;
    lf3[5] = 3'b101; laddr[5] = 32'h202; lexp[5] = 32'h0000_80FF;
    lf3[6] = 3'b100; laddr[6] = 32'h200; lexp[6] = 32'h0000_0001;
    dly[0] = 1; dly[1] = 4;
    mem_word = 32'h80FF_7F01;
    for (int d = 0; d < 2; d++) begin
      rvalid_delay = dly[d];
      for (int i = 0; i < 7; i++) begin
        applyStimulus(1, 0, lf3[i], laddr[i], 32'h0, 5'(i + 8), 1, 0, 1, lexp[i], 4'b1111, 32'h0, 1, 0);
        waitDrain("load_drain");
      end
    end

    // Misaligned and illegal accesses, issued back to back
    applyStimulus(1, 0, 3'b010, 32'h0000_0206, 32'h0, 5'd4, 1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    applyStimulus(0, 1, 3'b001, 32'h0000_0301, 32'h0, 5'd0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    applyStimulus(1, 0, 3'b011, 32'h0000_0200, 32'h0, 5'd6, 1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    applyStimulus(1, 1, 3'b010, 32'h0000_0040, 32'h0, 5'd7, 1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    waitDrain("err_drain");

    // Back-to-back ADDI, LW, ADD with ex_valid held high
    rvalid_delay = 1;
    applyStimulus(0, 0, 3'b000, 32'h0000_0011, 32'h0, 5'd1, 1, 0, 1, 32'h0000_0011, 4'h0, 32'h0, 1, 1);
    applyStimulus(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd2, 1, 0, 1, 32'h80FF_7F01, 4'b1111, 32'h0, 1, 0);
    applyStimulus(0, 0, 3'b000, 32'h0000_0022, 32'h0, 5'd3, 1, 0, 1, 32'h0000_0022, 4'h0, 32'h0, 1, 1);
    checkOutput("b2b_lw_stall_cycles", 32'(last_stalls), 32'd2);
    checkOutput("b2b_add_accept_cycle", 32'(last_accept_cyc), 32'(last_wb_cyc + 1));
    waitDrain("b2b_drain");

    // Reset during WAIT_R, with the load response arriving after reset is released
    rvalid_delay = 6;
    applyStimulus(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd9, 1, 0, 1, 32'h0, 4'b1111, 32'h0, 0, 0);
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("midrst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("midrst_ex_ready", 32'(ex_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("postrst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("postrst_ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("postrst_wb_valid", 32'(wb_valid), 32'd0);

    waitDrain("final_drain");
    checkOutput("final_req_queue", 32'(req_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It accepts one operation per handshake from the EX/MEM register and produces a registered MEM/WB result. ALU results pass through; loads and stores run against an external data-memory port with a request/grant/response handshake. Byte enables, store-data replication, load extraction with sign/zero extension, misalignment trapping and the pipeline stall (`ex_ready`) are all produced here.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: EX/MEM holds a valid operation.
- `ex_ready` out 1: LSU can accept; low means stall upstream.
- `ex_mem_read`, `ex_mem_write` in 1 each: load / store. Both low means ALU pass-through. Both high is illegal.
- `ex_funct3` in 3: RV32I width and sign code.
- `ex_addr` in 32: ALU result, used as the effective address.
- `ex_store_data` in 32: forwarded rs2 value.
- `ex_rd` in 5, `ex_wb_en` in 1: destination register and writeback enable.
- `dmem_req` out 1, `dmem_gnt` in 1: request and grant.
- `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0]=0), `dmem_be` out 4, `dmem_wdata` out 32.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `wb_valid` out 1: one-cycle pulse, MEM/WB result valid.
- `wb_en` out 1, `wb_rd` out 5, `wb_data` out 32: writeback fields.
- `lsu_err` out 1, `lsu_err_addr` out 32: misaligned or illegal access pulse, plus the captured address.

## Operation
- FSM has three states: IDLE, REQ, WAIT_R. `ex_ready = (state==IDLE)`. Accept when `ex_valid && ex_ready`.
- **Pass-through** (neither read nor write):
  - Next cycle: `wb_valid=1`, `wb_data=ex_addr`, `wb_rd=ex_rd`, `wb_en=ex_wb_en`.
  - State stays IDLE.
- **Legal funct3:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- **Misaligned or illegal access:**
  - Triggers: halfword with `addr[0]=1`, word with `addr[1:0]!=0`, illegal funct3, or read and write both high.
  - No memory request is issued.
  - Next cycle: `wb_valid=1`, `wb_en=0`, `lsu_err=1`, `lsu_err_addr=ex_addr`. State stays IDLE.
- **Memory op:** IDLE→REQ. Registered outputs are `dmem_req=1` and `dmem_addr={ex_addr[31:2],2'b00}`.
  - SB: `be=4'b0001<<a[1:0]`, `wdata={4{d[7:0]}}`.
  - SH: `be=4'b0011<<a[1:0]`, `wdata={2{d[15:0]}}`.
  - SW: `be=4'b1111`, `wdata=d`.
  - Loads: `be=4'b1111`, `we=0`.
- **REQ state:** all dmem outputs stay stable until `dmem_gnt`.
  - Store with gnt: drop req, go IDLE, `wb_valid` with `wb_en=0` next cycle.
  - Load with gnt: drop req, go WAIT_R.
- **WAIT_R state:** on `dmem_rvalid`, extract `dmem_rdata >> (8*a[1:0])`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Result goes to `wb_data` with `wb_en=ex_wb_en` and `wb_valid=1` next cycle. State goes to IDLE.
- `dmem_rvalid` outside WAIT_R is ignored. `ex_rd=0` passes through unchanged; the regfile ignores x0.

## Timing
- **Reset values:** state=IDLE, so `ex_ready=1`. All other outputs are 0: `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `wb_valid`, `wb_en`, `wb_rd`, `wb_data`, `lsu_err`, `lsu_err_addr`.
- **Reset mid-operation:** the transaction is abandoned and `dmem_req` drops immediately. A late rvalid is ignored.
- **Latencies,** with acceptance at edge N:
  - Pass-through and error: `wb_valid` in cycle N+1. Throughput is 1 per cycle.
  - Store: `dmem_req` in cycle N+1. If gnt is sampled at edge G, `wb_valid` is in cycle G+1. Minimum latency is 2 cycles.
  - Load: `dmem_rvalid` must come no earlier than the cycle after gnt. If rvalid is sampled at edge R, `wb_valid` is in cycle R+1. Minimum latency is 3 cycles.
- `wb_valid` and `lsu_err` are single-cycle pulses.
- `ex_ready` returns high in the same cycle `wb_valid` pulses for a memory op. A new op may be accepted at that edge.
- Upstream must hold `ex_*` stable while `ex_valid && !ex_ready`.

## Test plan
- **Reset state:** assert rst for 3 cycles → all outputs 0, `ex_ready=1`. Deassert, then send ADD result `ex_addr=0x0000_0007`, rd=5 → next cycle `wb_valid=1`, `wb_data=7`, `wb_rd=5`, `wb_en=1`.
- **SB:** addr 0x0000_0103, data 0x1234_56AB → `dmem_addr=0x100`, `be=4'b1000`, `wdata=0xABAB_ABAB`, `we=1`. With gnt held low for 2 cycles, req and outputs stay stable and `ex_ready=0`. After gnt, `wb_valid` pulses with `wb_en=0`.
- **Loads from one word:** memory word at 0x200 is 0x80FF_7F01.
  - LB 0x201 → `wb_data=0x0000_007F`.
  - LB 0x203 → `0xFFFF_FF80`.
  - LBU 0x202 → `0x0000_00FF`.
  - LH 0x202 → `0xFFFF_80FF`.
  - LW 0x200 → `0x80FF_7F01`.
  - Each case has rvalid delays of 1 and 4 cycles.
- **Misaligned:** LW at 0x0000_0206 → no `dmem_req`, `lsu_err=1`, `lsu_err_addr=0x206`, `wb_en=0`. SH at 0x301 → same behaviour.
- **Back-to-back:** ADDI, LW, ADD with ex_valid held → ADDI `wb_valid` next cycle. LW stalls upstream (`ex_ready=0`) until its response. ADD is accepted in the LW `wb_valid` cycle.
- **Reset mid-load:** assert rst in WAIT_R, then drive rvalid after deassertion → no `wb_valid`, state IDLE, `dmem_req=0`.
